// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/DMA request buses and data-memory port of dmem_arbiter
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_gnt;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        misalign_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_read_data,
    output cpu_rdata, cpu_stall, cpu_gnt,
    output dma_gnt, dma_rvalid, dma_rdata, misalign_err,
    output mem_address, mem_write_data, mem_write_en, mem_read_en
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_read_data,
    input  cpu_rdata, cpu_stall, cpu_gnt,
    input  dma_gnt, dma_rvalid, dma_rdata, misalign_err,
    input  mem_address, mem_write_data, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority arbiter with DMA starvation bound for the single-port data memory
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             dma_rvalid_q, dma_rvalid_d;
  logic [31:0]      dma_rdata_q, dma_rdata_d;
  logic             misalign_q, misalign_d;

  logic        cpu_gnt, dma_gnt, any_gnt, sel_we, aligned;
  logic [31:0] sel_addr, sel_wdata, rd_data;

  // Grants are gated by rst_n so a write in flight is dropped the moment reset asserts.
  always_comb begin
    cpu_gnt = rst_n && bus.cpu_req && (!bus.dma_req || (starve_cnt_q < LIMIT));
    dma_gnt = rst_n && bus.dma_req && !cpu_gnt;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (cpu_gnt) begin
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      sel_we    = bus.cpu_we;
    end else if (dma_gnt) begin
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
      sel_we    = bus.dma_we;
    end
  end

  assign any_gnt = cpu_gnt | dma_gnt;
  assign aligned = (sel_addr[1:0] == 2'b00);
  assign rd_data = aligned ? bus.mem_read_data : '0;

  assign bus.cpu_gnt        = cpu_gnt;
  assign bus.dma_gnt        = dma_gnt;
  assign bus.cpu_stall      = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rdata      = (cpu_gnt && !sel_we) ? rd_data : '0;
  assign bus.mem_address    = sel_addr;
  assign bus.mem_write_data = sel_wdata;
  assign bus.mem_write_en   = any_gnt & sel_we & aligned;
  assign bus.mem_read_en    = any_gnt & ~sel_we & aligned;
  assign bus.dma_rvalid     = dma_rvalid_q;
  assign bus.dma_rdata      = dma_rdata_q;
  assign bus.misalign_err   = misalign_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dma_gnt || !bus.dma_req) begin
      starve_cnt_d = '0;
    end else if (cpu_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    dma_rvalid_d = dma_gnt & ~bus.dma_we;
    dma_rdata_d  = dma_rvalid_d ? rd_data : dma_rdata_q;
    misalign_d   = any_gnt & ~aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      misalign_q   <= misalign_d;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port 256×32 data memory of the pipelined MIPS32 core. It shares the memory between the pipeline MEM stage (CPU port) and a DMA/loader port. The CPU has priority, and a starvation counter bounds the DMA wait time. The block stalls the pipeline when the CPU loses arbitration, registers DMA read data, and blocks misaligned accesses.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the DMA may lose to the CPU before it is forced a grant; legal range 1..15
- CNT_W, 4: width of the starvation counter
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM-stage access request; held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, combinational, valid in the grant cycle
- cpu_stall  out  1  freeze the pipeline: cpu_req and not cpu_gnt
- cpu_gnt  out  1  CPU access performed this cycle
- dma_req, dma_we  in  1  DMA request and write enable; held until dma_gnt
- dma_addr, dma_wdata  in  32  DMA byte address and write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rvalid  out  1  registered; pulses 1 cycle after a DMA read grant
- dma_rdata  out  32  registered DMA read data
- misalign_err  out  1  registered; pulses 1 cycle after any granted access with addr[1:0] != 0
- mem_address, mem_write_data  out  32  to data memory
- mem_write_en, mem_read_en  out  1  to data memory
- mem_read_data  in  32  from data memory (combinational read)

## Operation
- Grant is combinational from the requests and the registered starve_cnt. At most one grant per cycle.
- Priority:
  - Only one requester active: it is granted.
  - Both active and starve_cnt < STARVE_LIMIT: CPU is granted.
  - Both active and starve_cnt == STARVE_LIMIT: DMA is granted and the CPU stalls.
- starve_cnt update, in priority order:
  - Reset to 0 on dma_gnt, or when dma_req = 0.
  - Otherwise increment when dma_req = 1 and the CPU is granted.
  - Saturates at STARVE_LIMIT.
- Memory muxing:
  - mem_address and mem_write_data come from the granted port.
  - With no grant, mem_address and mem_write_data are 0, and mem_write_en and mem_read_en are 0.
  - mem_write_en = grant & we & aligned.
  - mem_read_en = grant & ~we & aligned.
- Misaligned access (addr[1:0] != 0):
  - The grant still completes, so the requester is not hung.
  - No memory write is issued; read data returns 0.
  - misalign_err pulses for 1 cycle on the next edge.
- CPU read:
  - cpu_rdata = mem_read_data when cpu_gnt and ~cpu_we; otherwise 0.
- DMA read:
  - On a read grant, dma_rdata <= mem_read_data (or 0 if misaligned) and dma_rvalid <= 1.
  - dma_rvalid <= 0 in every other cycle.
  - dma_rdata holds its last value.
- DMA writes produce no dma_rvalid.

## Timing
- Reset (rst_n = 0, asynchronous):
  - starve_cnt = 0, dma_rvalid = 0, dma_rdata = 0, misalign_err = 0.
  - All grants, mem_write_en and mem_read_en are forced 0.
  - cpu_stall = cpu_req while in reset.
- CPU access latency: 0 cycles when uncontended. The load result is available in the grant cycle.
- DMA access latency:
  - Write completes in the dma_gnt cycle.
  - Read data arrives with dma_rvalid at grant + 1.
- Worst-case DMA wait under continuous CPU traffic: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT + 1.
- Worst-case CPU stall: 1 cycle per forced DMA grant. After a DMA grant, starve_cnt = 0, so the CPU wins the next contended cycle.
- Request rule: a requester holds req, we, addr and wdata stable until it sees its grant. Back-to-back requests are legal in consecutive cycles.
- Reset asserted mid-access: the in-flight write is suppressed immediately and the pending dma_rvalid is cleared.
- Simultaneous read and write to the same address by different ports: serialized by grant order, with no forwarding.

## Test plan
- Reset: rst_n = 0 with cpu_req = dma_req = 1 -> cpu_gnt = dma_gnt = 0, mem_write_en = 0, dma_rvalid = 0, cpu_stall = 1. Release -> CPU granted in the first cycle.
- CPU only: store 0xDEADBEEF to 0x40, then load 0x40 -> cpu_stall = 0 throughout, mem_address = 0x40, and cpu_rdata = 0xDEADBEEF in the load cycle.
- DMA only: write 0x12345678 to 0x80, then read 0x80 -> dma_gnt each cycle, dma_rvalid = 1 one cycle after the read grant, dma_rdata = 0x12345678.
- Contention, STARVE_LIMIT = 4: cpu_req and dma_req held high continuously -> grant pattern CPU×4, DMA×1, repeating. cpu_stall = 1 exactly in each DMA cycle. starve_cnt sequence is 0, 1, 2, 3, 4, 0.
- Starvation reset: DMA waits 2 cycles, drops dma_req for 1 cycle, then reasserts -> starve_cnt restarts from 0, and DMA waits a further 4 cycles.
- Misaligned: CPU store to 0x42 -> cpu_gnt = 1, mem_write_en = 0, misalign_err pulses at the next edge. DMA read of 0x81 -> dma_rvalid = 1, dma_rdata = 0, misalign_err = 1.
